// File: rtl/seven_seg_scan_ctrl_pkg.sv
// rtl/seven_seg_scan_ctrl_pkg.sv - shared constants, types and blank rule for the digit scanner
package seven_seg_scan_ctrl_pkg;

    localparam int NUM_DIGITS           = 4;
    localparam int SLOT_W               = 2;
    localparam int NIBBLE_W             = 4;
    localparam int DEFAULT_REFRESH_DIV  = 100000;
    localparam int DEFAULT_BLINK_FRAMES = 125;

    typedef logic [SLOT_W-1:0]   slot_t;
    typedef logic [NIBBLE_W-1:0] nibble_t;

    // Blink applies to any masked slot; leading-zero blanking only to the most significant slot.
    function automatic logic slot_blank(
        input slot_t                 slot,
        input logic [NUM_DIGITS-1:0] mask,
        input logic                  phase,
        input logic                  lz,
        input nibble_t               msd
    );
        return (mask[slot] & phase) |
               ((slot == slot_t'(NUM_DIGITS - 1)) & lz & (msd == '0));
    endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_prescaler.sv
// rtl/seven_seg_scan_ctrl_prescaler.sv - refresh divider producing a one-cycle slot tick
module scan_prescaler
    import seven_seg_scan_ctrl_pkg::*;
#(
    parameter int DIV = DEFAULT_REFRESH_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int            CW   = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = (count_q == LAST);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - four-slot display scan scheduler with frame snapshot, blink and leading-zero blank
module seven_seg_scan_ctrl
    import seven_seg_scan_ctrl_pkg::*;
#(
    parameter int REFRESH_DIV  = DEFAULT_REFRESH_DIV,
    parameter int BLINK_FRAMES = DEFAULT_BLINK_FRAMES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  disp_en,
    input  logic [NIBBLE_W-1:0]   digit0,
    input  logic [NIBBLE_W-1:0]   digit1,
    input  logic [NIBBLE_W-1:0]   digit2,
    input  logic [NIBBLE_W-1:0]   digit3,
    input  logic [NUM_DIGITS-1:0] blink_mask,
    input  logic                  lz_blank_en,
    output logic [SLOT_W-1:0]     digit_sel,
    output logic [NIBBLE_W-1:0]   digit_val,
    output logic                  digit_blank,
    output logic                  frame_start
);

    localparam int             FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

    logic tick;

    scan_prescaler #(
        .DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    slot_t                               digit_sel_q,   digit_sel_d;
    nibble_t                             digit_val_q,   digit_val_d;
    logic                                digit_blank_q, digit_blank_d;
    logic                                frame_start_q, frame_start_d;
    logic                                slot_blank_q,  slot_blank_d;
    logic                                blink_phase_q, blink_phase_d;
    logic [FC_W-1:0]                     frame_cnt_q,   frame_cnt_d;
    logic [NUM_DIGITS-1:0][NIBBLE_W-1:0] snap_q,        snap_d;
    logic [NUM_DIGITS-1:0]               mask_snap_q,   mask_snap_d;
    logic                                lz_snap_q,     lz_snap_d;
    slot_t                               next_slot;

    always_comb begin
        digit_sel_d   = digit_sel_q;
        digit_val_d   = digit_val_q;
        frame_start_d = 1'b0;
        slot_blank_d  = slot_blank_q;
        blink_phase_d = blink_phase_q;
        frame_cnt_d   = frame_cnt_q;
        snap_d        = snap_q;
        mask_snap_d   = mask_snap_q;
        lz_snap_d     = lz_snap_q;
        next_slot     = digit_sel_q + slot_t'(1);

        if (tick) begin
            digit_sel_d = next_slot;
            // Frame boundary: the new snapshot and phase must already govern slot 0 of this frame.
            if (digit_sel_q == slot_t'(NUM_DIGITS - 1)) begin
                snap_d        = {digit3, digit2, digit1, digit0};
                mask_snap_d   = blink_mask;
                lz_snap_d     = lz_blank_en;
                frame_start_d = 1'b1;
                if (frame_cnt_q == FC_LAST) begin
                    frame_cnt_d   = '0;
                    blink_phase_d = ~blink_phase_q;
                end else begin
                    frame_cnt_d = frame_cnt_q + FC_W'(1);
                end
            end
            digit_val_d  = snap_d[next_slot];
            slot_blank_d = slot_blank(next_slot, mask_snap_d, blink_phase_d, lz_snap_d,
                                      snap_d[NUM_DIGITS-1]);
        end

        digit_blank_d = ~disp_en | slot_blank_d;
    end

    // The slot flag resets high so the display stays dark until the first slot is loaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            digit_sel_q   <= '0;
            digit_val_q   <= '0;
            digit_blank_q <= 1'b1;
            frame_start_q <= 1'b0;
            slot_blank_q  <= 1'b1;
            blink_phase_q <= 1'b0;
            frame_cnt_q   <= '0;
            snap_q        <= '0;
            mask_snap_q   <= '0;
            lz_snap_q     <= 1'b0;
        end else begin
            digit_sel_q   <= digit_sel_d;
            digit_val_q   <= digit_val_d;
            digit_blank_q <= digit_blank_d;
            frame_start_q <= frame_start_d;
            slot_blank_q  <= slot_blank_d;
            blink_phase_q <= blink_phase_d;
            frame_cnt_q   <= frame_cnt_d;
            snap_q        <= snap_d;
            mask_snap_q   <= mask_snap_d;
            lz_snap_q     <= lz_snap_d;
        end
    end

    assign digit_sel   = digit_sel_q;
    assign digit_val   = digit_val_q;
    assign digit_blank = digit_blank_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - vector table, corner sequences and random run against a tick-count model
module tb_seven_seg_scan_ctrl;

    localparam int RD = 4;
    localparam int BF = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       disp_en = 1'b0;
    logic [3:0] digit0 = 4'd4, digit1 = 4'd3, digit2 = 4'd2, digit3 = 4'd1;
    logic [3:0] blink_mask = 4'd0;
    logic       lz_blank_en = 1'b0;
    logic [1:0] digit_sel;
    logic [3:0] digit_val;
    logic       digit_blank;
    logic       frame_start;

    seven_seg_scan_ctrl #(
        .REFRESH_DIV  (RD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .disp_en     (disp_en),
        .digit0      (digit0),
        .digit1      (digit1),
        .digit2      (digit2),
        .digit3      (digit3),
        .blink_mask  (blink_mask),
        .lz_blank_en (lz_blank_en),
        .digit_sel   (digit_sel),
        .digit_val   (digit_val),
        .digit_blank (digit_blank),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int         mj;
    logic [3:0] msnap [4];
    logic [3:0] mmask;
    logic       mlz;
    logic [1:0] e_sel;
    logic [3:0] e_val;
    logic       e_blank;
    logic       e_fs;

    typedef struct {
        logic       rst;
        logic       en;
        int         ncyc;
        logic [1:0] sel;
        logic [3:0] val;
        logic       blank;
        logic       fs;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Everything follows from edges since reset: ticks = edges/RD, slot = ticks%4, frame = ticks/4.
    task automatic model_edge();
        int   n;
        int   slot;
        int   frames;
        logic phase;
        logic flag;
        if (reset) begin
            mj = 0;
            for (int i = 0; i < 4; i++) msnap[i] = 4'd0;
            mmask = 4'd0; mlz = 1'b0;
            e_sel = 2'd0; e_val = 4'd0; e_blank = 1'b1; e_fs = 1'b0;
        end else begin
            mj++;
            n      = mj / RD;
            slot   = n % 4;
            frames = n / 4;
            e_fs   = (mj % RD == 0) && (n > 0) && (slot == 0);
            if (e_fs) begin
                msnap = '{digit0, digit1, digit2, digit3};
                mmask = blink_mask;
                mlz   = lz_blank_en;
            end
            phase = ((frames / BF) % 2) == 1;
            if (n == 0) flag = 1'b1;
            else flag = (mmask[slot] && phase) || (slot == 3 && mlz && msnap[3] == 4'd0);
            e_sel   = 2'(slot);
            e_val   = msnap[slot];
            e_blank = !disp_en || flag;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("model", 32'({digit_sel, digit_val, digit_blank, frame_start}),
                       32'({e_sel, e_val, e_blank, e_fs}));
    endtask

    task automatic wait_enter(input logic [1:0] s);
        logic [1:0] prev;
        for (int i = 0; i < 80; i++) begin
            prev = digit_sel;
            cyc();
            if (digit_sel == s && prev != s) return;
        end
        n_checks++;
        $display("FAIL wait_sel_%0d: slot never entered within 80 cycles", s);
    endtask

    task automatic wait_fs();
        for (int i = 0; i < 80; i++) begin
            cyc();
            if (frame_start) return;
        end
        n_checks++;
        $display("FAIL wait_frame_start: no pulse within 80 cycles");
    endtask

    logic bl [8];
    int   ones;
    int   cnt;

    initial begin
        //           rst   en    ncyc sel   val   blank fs
        vecs[0]  = '{1'b1, 1'b1, 1,   2'd0, 4'd0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 3,   2'd0, 4'd0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1,   2'd1, 4'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 4,   2'd2, 4'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 8,   2'd0, 4'd4, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 1,   2'd0, 4'd4, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 3,   2'd1, 4'd3, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 4,   2'd2, 4'd2, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 4,   2'd3, 4'd1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 4,   2'd0, 4'd4, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1,   2'd0, 4'd4, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1,   2'd0, 4'd4, 1'b0, 1'b0};

        for (int v = 0; v < 12; v++) begin
            reset   = vecs[v].rst;
            disp_en = vecs[v].en;
            for (int c = 0; c < vecs[v].ncyc; c++) cyc();
            check($sformatf("vec%0d", v),
                  32'({digit_sel, digit_val, digit_blank, frame_start}),
                  32'({vecs[v].sel, vecs[v].val, vecs[v].blank, vecs[v].fs}));
        end

        // Snapshot: a change during the frame shows up only in the next frame.
        wait_enter(2'd1);
        check("snap_before", 32'(digit_val), 32'd3);
        digit1 = 4'd9;
        cyc(); cyc();
        check("snap_hold", 32'(digit_val), 32'd3);
        wait_enter(2'd1);
        check("snap_next", 32'(digit_val), 32'd9);

        // Blink on slot 0: two frames one way, two frames the other.
        blink_mask = 4'b0001;
        wait_fs();
        bl[0] = digit_blank;
        for (int f = 1; f < 8; f++) begin
            wait_fs();
            bl[f] = digit_blank;
        end
        ones = 0;
        for (int f = 0; f < 8; f++) ones += int'(bl[f]);
        for (int f = 0; f < 6; f++) check($sformatf("blink_period%0d", f), 32'(bl[f] ^ bl[f+2]), 32'd1);
        check("blink_duty", 32'(ones), 32'd4);

        // Leading zero.
        blink_mask = 4'd0; digit3 = 4'd0; digit2 = 4'd0; lz_blank_en = 1'b1;
        wait_fs();
        wait_enter(2'd2);
        check("zero_slot2", 32'({digit_val, digit_blank}), 32'({4'd0, 1'b0}));
        wait_enter(2'd3);
        check("lz_blank", 32'({digit_val, digit_blank}), 32'({4'd0, 1'b1}));
        lz_blank_en = 1'b0;
        wait_fs();
        wait_enter(2'd3);
        check("lz_off", 32'({digit_val, digit_blank}), 32'({4'd0, 1'b0}));

        // Enable dropped mid-slot while scanning continues.
        wait_enter(2'd1);
        cyc();
        disp_en = 1'b0;
        cyc();
        check("en_off", 32'({digit_sel, digit_blank}), 32'({2'd1, 1'b1}));
        disp_en = 1'b1;
        cyc();
        check("en_on", 32'({digit_sel, digit_blank}), 32'({2'd1, 1'b0}));

        // Reset mid-frame.
        wait_enter(2'd2);
        reset = 1'b1;
        cyc();
        check("reset_mid", 32'({digit_sel, digit_val, digit_blank, frame_start}), 32'({2'd0, 4'd0, 1'b1, 1'b0}));
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            cnt++;
            if (frame_start) break;
        end
        check("first_fs_latency", 32'(cnt), 32'd16);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            reset   = ($urandom_range(0, 499) == 0);
            disp_en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: digit0 = 4'($urandom);
                    1: digit1 = 4'($urandom);
                    2: digit2 = 4'($urandom);
                    default: digit3 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
                endcase
            end
            if ($urandom_range(0, 63) == 0) blink_mask = 4'($urandom);
            if ($urandom_range(0, 63) == 0) lz_blank_en = 1'($urandom);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
